// File: rtl/clkset_pkg.sv
// Shared types and constants for the digital-clock set controller.
package clkset_pkg;

    // Encoding doubles as the blink_sel field code.
    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StSetHr  = 2'd1,
        StSetMin = 2'd2,
        StSetSec = 2'd3
    } state_e;

    localparam logic [7:0] BCD_59 = 8'h59;
    localparam logic [7:0] BCD_00 = 8'h00;

    function automatic state_e next_mode(input state_e s);
        unique case (s)
            StRun:    next_mode = StSetHr;
            StSetHr:  next_mode = StSetMin;
            StSetMin: next_mode = StSetSec;
            default:  next_mode = StRun;
        endcase
    endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Tick counter that flags a set-mode timeout; built only with CLKSET_AUTOEXIT_EN.
`ifdef CLKSET_AUTOEXIT_EN
module inactivity_timer #(
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic CP,
    input  logic CLR,
    input  logic clr_cnt,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT_TICKS + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Fires on the tick that completes the window so the FSM leaves on the next cycle.
    assign expired = tick && !clr_cnt && (cnt_q == CntW'(TIMEOUT_TICKS - 1));

    always_ff @(posedge CP) begin
        if (CLR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/clock_set_ctrl.sv
// Mode/sequence controller for the clock counter chain: run-time carries and time-set mode.
// Optional auto-exit from set mode when CLKSET_AUTOEXIT_EN is defined.
module clock_set_ctrl
    import clkset_pkg::*;
#(
    parameter logic [7:0]  HR_MAX        = 8'h23,
    parameter int unsigned TIMEOUT_TICKS = 10
) (
    input  logic       CP,
    input  logic       CLR,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [7:0] sec_q,
    input  logic [7:0] min_q,
    input  logic [7:0] hr_q,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic       dir,
    output logic       sec_load,
    output logic [1:0] blink_sel,
    output logic       blink
);

    state_e state_q, state_d;
    logic   sec_en_q, sec_en_d;
    logic   min_en_q, min_en_d;
    logic   hr_en_q, hr_en_d;
    logic   dir_q, dir_d;
    logic   sec_load_q, sec_load_d;
    logic   blink_q, blink_d;
    logic   timeout;

    // Field wrapping lives in the counters; hours value and limit are informational here.
    logic unused_cfg;
    assign unused_cfg = ^{hr_q, HR_MAX, TIMEOUT_TICKS};

`ifdef CLKSET_AUTOEXIT_EN
    logic clr_cnt;
    assign clr_cnt = (state_q == StRun) || btn_mode || btn_up || btn_down;

    inactivity_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS)
    ) u_inactivity_timer (
        .CP     (CP),
        .CLR    (CLR),
        .clr_cnt(clr_cnt),
        .tick   (tick),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        sec_en_d   = 1'b0;
        min_en_d   = 1'b0;
        hr_en_d    = 1'b0;
        sec_load_d = 1'b0;
        dir_d      = dir_q;
        blink_d    = blink_q;

        if (state_q == StRun) begin
            if (tick) begin
                sec_en_d = 1'b1;
                dir_d    = 1'b1;
                min_en_d = (sec_q == BCD_59);
                hr_en_d  = (sec_q == BCD_59) && (min_q == BCD_59);
            end
            if (btn_mode) begin
                state_d = StSetHr;
            end
        end else begin
            if (tick) begin
                blink_d = ~blink_q;
            end
            // Mode wins over keys; up and down together cancel out.
            if (btn_mode) begin
                state_d = next_mode(state_q);
            end else if (btn_up ^ btn_down) begin
                if (state_q == StSetSec) begin
                    sec_load_d = 1'b1;
                end else begin
                    dir_d = btn_up;
                    if (state_q == StSetHr) begin
                        hr_en_d = 1'b1;
                    end else begin
                        min_en_d = 1'b1;
                    end
                end
            end
            if (timeout) begin
                state_d = StRun;
            end
            if (state_d == StRun) begin
                blink_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CP) begin
        if (CLR) begin
            state_q    <= StRun;
            sec_en_q   <= 1'b0;
            min_en_q   <= 1'b0;
            hr_en_q    <= 1'b0;
            dir_q      <= 1'b1;
            sec_load_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_en_q   <= sec_en_d;
            min_en_q   <= min_en_d;
            hr_en_q    <= hr_en_d;
            dir_q      <= dir_d;
            sec_load_q <= sec_load_d;
            blink_q    <= blink_d;
        end
    end

    assign sec_en    = sec_en_q;
    assign min_en    = min_en_q;
    assign hr_en     = hr_en_q;
    assign dir       = dir_q;
    assign sec_load  = sec_load_q;
    assign blink_sel = state_q;
    assign blink     = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed table-driven bench for clock_set_ctrl, plus set-mode timeout sequences.
module tb_clock_set_ctrl;

    logic       CP = 1'b0;
    logic       CLR, tick, btn_mode, btn_up, btn_down;
    logic [7:0] sec_q, min_q, hr_q;
    logic       sec_en, min_en, hr_en, dir, sec_load, blink;
    logic [1:0] blink_sel;

    int checks = 0;
    int errors = 0;

    always #5 CP = ~CP;

    clock_set_ctrl dut (
        .CP       (CP),
        .CLR      (CLR),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sec_q    (sec_q),
        .min_q    (min_q),
        .hr_q     (hr_q),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .hr_en    (hr_en),
        .dir      (dir),
        .sec_load (sec_load),
        .blink_sel(blink_sel),
        .blink    (blink)
    );

    // Outputs packed as {sec_en, min_en, hr_en, dir, sec_load, blink_sel[1:0], blink}.
    typedef struct packed {
        logic       clr, tck, mode, up, dn;
        logic [7:0] sec, min, hr;
        logic [7:0] exp;
    } vec_t;

    localparam int NVec = 27;
    vec_t vecs [NVec];

    task automatic drive(input logic c, input logic t, input logic m, input logic u,
                         input logic d, input logic [7:0] s, input logic [7:0] mi,
                         input logic [7:0] h);
        @(negedge CP);
        CLR = c; tick = t; btn_mode = m; btn_up = u; btn_down = d;
        sec_q = s; min_q = mi; hr_q = h;
        @(posedge CP);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {sec_en, min_en, hr_en, dir, sec_load, blink_sel, blink};
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    initial begin
        //           clr tck mod up  dn  sec    min    hr     exp {se me he dr ld bs bl}
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0001_0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0001_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0001_0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h12, 8'b1111_0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h58, 8'h59, 8'h12, 8'b1001_0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h10, 8'h12, 8'b1101_0000};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 8'b0001_0000};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0001_0010};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'b0010_0010};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h23, 8'b0000_0010};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h23, 8'b0011_0010};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'b0001_0010};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h00, 8'b0001_0011};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h00, 8'b0001_0010};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h00, 8'b0001_0011};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0001_0101};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'b0100_0101};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h59, 8'h00, 8'b0100_0100};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0000_0110};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h33, 8'h00, 8'h00, 8'b0000_1110};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'b0000_1110};
        vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h00, 8'b0000_0111};
        vecs[22] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'b0000_0000};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'b1001_0000};
        vecs[24] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05, 8'b0001_0010};
        vecs[25] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h05, 8'b0001_0000};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h05, 8'b0001_0000};

        CLR = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        sec_q = 8'h00; min_q = 8'h00; hr_q = 8'h00;

        for (int i = 0; i < NVec; i++) begin
            drive(vecs[i].clr, vecs[i].tck, vecs[i].mode, vecs[i].up, vecs[i].dn,
                  vecs[i].sec, vecs[i].min, vecs[i].hr);
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Enter SET_MIN from RUN.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        check("enter_set_min", {6'b0, blink_sel}, 8'd2);
`ifdef CLKSET_AUTOEXIT_EN
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        end
        check("before_restart", {6'b0, blink_sel}, 8'd2);
        // Key on the ninth tick restarts the inactivity window.
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 8'h30, 8'h10);
        check("restart_key", {min_en, dir, 4'b0, blink_sel}, 8'b1100_0010);
        for (int k = 1; k <= 9; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
            check($sformatf("hold_tick%0d", k), {6'b0, blink_sel}, 8'd2);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        check("autoexit", {sec_en, min_en, hr_en, blink, 2'b0, blink_sel}, 8'b0000_0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        check("run_after_exit", outs(), 8'b1001_0000);
`else
        for (int k = 1; k <= 12; k++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h59, 8'h59, 8'h10);
            check($sformatf("no_exit_tick%0d", k), outs(), {7'b0001_010, 1'(k % 2)});
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h30, 8'h10);
        check("mode_to_run", outs(), 8'b0001_0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
